fb_reader: RTL and testbench
============================

# fb_reader

Framebuffer read-side engine: turns the VGA driver's `next_x`/`next_y` scan position into read addresses for the dual-port framebuffer RAM and returns the pixel colour, centred on a 640x480 screen. The ROM-to-RAM copier owns the write port; this block owns the read port and sits between the RAM `q` output and the VGA driver's `color_in`. Display mode follows `seletor`, but a new mode is shown only after the copier reports `done` and a frame boundary is reached, so partial images and mid-frame geometry changes are never displayed.

## Interface
- `IMG_W`, default 160: source image width in pixels.
- `IMG_H`, default 120: source image height in pixels.
- `FATOR`, default 2: scale factor, used for both zoom and decimation.
- `SCREEN_W`, default 640: visible screen width.
- `SCREEN_H`, default 480: visible screen height.
- `RD_LAT`, default 1: cycles from a `ram_rdaddr` change until `ram_q` is valid.

Ports:
- `clk` in 1: pixel clock (25 MHz).
- `reset` in 1: asynchronous, active-low reset.
- `seletor` in 2: requested mode. 00 = replication, 01 = decimation, 10 = zoom_nn, 11 = invalid.
- `copy_done` in 1: copier finished filling the RAM; level signal.
- `next_x` in 10: upcoming pixel column from the VGA driver.
- `next_y` in 10: upcoming pixel row from the VGA driver.
- `ram_rdaddr` out 19: framebuffer read address.
- `ram_q` in 8: framebuffer read data.
- `color_out` out 8: pixel colour to the VGA driver; 0 = black.
- `active` out 1: high while state ACTIVE.
- `mode_cur` out 2: latched mode currently displayed.
- `frame_start` out 1: one-cycle pulse at each frame boundary seen in ACTIVE.

## Operation

**Reset values**
- State WAIT_COPY.
- `ram_rdaddr` = 0, `color_out` = 0, `active` = 0, `mode_cur` = 2'b11, `frame_start` = 0.
- All pipeline registers cleared.

**State machine**
- WAIT_COPY: blank output. Go to WAIT_FRAME when `copy_done` = 1 and `seletor` != 11.
- WAIT_FRAME: blank output. At the frame boundary (`next_x` = 0 and `next_y` = 0), latch `mode_cur` <= `seletor` and go to ACTIVE.
- ACTIVE: generate addresses and colour. `frame_start` pulses on each boundary.
- In WAIT_FRAME or ACTIVE, if `seletor` != `mode_cur` (WAIT_FRAME: != value seen on entry), or `copy_done` falls, go to WAIT_COPY.
- The mode-change check has priority over a coincident frame boundary.

**Geometry** (from `mode_cur`)
- Modes 00 and 10: W_AMP = `IMG_W`*`FATOR` = 320, H_AMP = 240.
- Mode 01: W_AMP = `IMG_W`/`FATOR` = 80, H_AMP = 60.
- Offsets: x_off = (`SCREEN_W` - W_AMP)/2, y_off = (`SCREEN_H` - H_AMP)/2. Result: 160/120 for modes 00 and 10; 280/210 for mode 01.
- Offsets are registered on the `mode_cur` update, not recomputed per pixel.
- in_img = ACTIVE and x_off <= `next_x` < x_off+W_AMP and y_off <= `next_y` < y_off+H_AMP.
- `next_x` >= 640 or `next_y` >= 480 (blanking region) always gives in_img = 0.

**Address**
- `ram_rdaddr` = (`next_y`-y_off)*W_AMP + (`next_x`-x_off) when in_img, else 0.
- Unsigned arithmetic. Maximum address is 76799, which fits 17 bits; zero-extend to 19 bits. No wrap is possible.

**Colour**
- in_img is delayed through a RD_LAT+1 deep shift register.
- `color_out` <= delayed in_img ? `ram_q` : 0.

## Timing
- Cycle n: `next_x`/`next_y` presented. Cycle n+1: `ram_rdaddr` valid (registered). Cycle n+1+RD_LAT: `ram_q` valid. Cycle n+2+RD_LAT: `color_out` valid, which is n+3 for the default `RD_LAT`.
- Total pipeline latency is fixed at RD_LAT+2 cycles. The VGA driver compensates by presenting `next_*` ahead of the beam.
- Boundary latch: WAIT_FRAME -> ACTIVE on the clock edge where `next_x` = 0 and `next_y` = 0 are sampled.
- `frame_start` is high the cycle after a boundary is sampled in ACTIVE. It is not issued on the entry boundary.
- Leaving ACTIVE: `color_out` is forced to 0 from the next cycle. In-flight pipeline data is discarded by clearing the in_img delay line.
- Reset deassertion mid-frame: stay in WAIT_COPY until `copy_done` = 1, then wait for a full frame boundary before showing anything.

## Test plan
- Reset, then `seletor` = 00, `copy_done` = 1, sweep a frame. Expect black until the first (0,0). Next frame: `next_x` = 160, `next_y` = 120 gives `ram_rdaddr` = 0; (479,359) gives 76799; (159,120) gives `color_out` 0.
- Mode 01, `ram_q` = 8'hA5 constant: (280,210) gives `ram_rdaddr` 0 and `color_out` A5 three cycles later. (360,210) is outside the image, so `color_out` 0. (359,269) gives address 4799.
- Switch `seletor` 00->01 mid-frame with `copy_done` low for 10 cycles then high. Expect `active` 0 immediately, black until the next (0,0), then `mode_cur` = 01.
- `seletor` = 11: `active` stays 0 and `color_out` stays 0 for the whole frame, whatever `ram_q` is.
- Assert `reset` low mid-line. All outputs go to their reset values asynchronously, `mode_cur` = 11, and there is no output until `copy_done` plus a boundary.
- Latency check with `RD_LAT` = 2: the `color_out` edge appears 4 cycles after `next_x` enters the image region; `frame_start` pulses once per frame.

Source files
------------

// File: rtl/fb_reader.sv
// Framebuffer read-side engine: maps the VGA scan position to framebuffer read
// addresses and returns the centred pixel colour, switching modes only on frame boundaries.
module fb_reader #(
  parameter int IMG_W    = 160,
  parameter int IMG_H    = 120,
  parameter int FATOR    = 2,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int RD_LAT   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  seletor,
  input  logic        copy_done,
  input  logic [9:0]  next_x,
  input  logic [9:0]  next_y,
  output logic [18:0] ram_rdaddr,
  input  logic [7:0]  ram_q,
  output logic [7:0]  color_out,
  output logic        active,
  output logic [1:0]  mode_cur,
  output logic        frame_start
);

  localparam int W_BIG = IMG_W * FATOR;
  localparam int H_BIG = IMG_H * FATOR;
  localparam int W_SML = IMG_W / FATOR;
  localparam int H_SML = IMG_H / FATOR;

  localparam logic [9:0] XOFF_BIG = 10'((SCREEN_W - W_BIG) / 2);
  localparam logic [9:0] YOFF_BIG = 10'((SCREEN_H - H_BIG) / 2);
  localparam logic [9:0] XOFF_SML = 10'((SCREEN_W - W_SML) / 2);
  localparam logic [9:0] YOFF_SML = 10'((SCREEN_H - H_SML) / 2);

  typedef enum logic [1:0] {
    WAIT_COPY  = 2'd0,
    WAIT_FRAME = 2'd1,
    ACTIVE     = 2'd2
  } state_t;

  state_t      state, next_state;
  logic [1:0]  entry_sel;
  logic [9:0]  x_lo, x_hi, y_lo, y_hi, w_amp;
  logic        boundary;
  logic        in_img;
  logic [18:0] addr_calc;
  logic [RD_LAT:0] img_dly;

  assign boundary = (next_x == 10'd0) && (next_y == 10'd0);

  // State plus the mode/geometry latched only when the display actually starts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= WAIT_COPY;
      entry_sel <= 2'b11;
      mode_cur  <= 2'b11;
      x_lo      <= '0;
      x_hi      <= '0;
      y_lo      <= '0;
      y_hi      <= '0;
      w_amp     <= '0;
    end else begin
      state <= next_state;
      if (state == WAIT_COPY && next_state == WAIT_FRAME)
        entry_sel <= seletor;
      if (state == WAIT_FRAME && next_state == ACTIVE) begin
        mode_cur <= seletor;
        if (seletor == 2'b01) begin
          x_lo  <= XOFF_SML;
          x_hi  <= XOFF_SML + 10'(W_SML);
          y_lo  <= YOFF_SML;
          y_hi  <= YOFF_SML + 10'(H_SML);
          w_amp <= 10'(W_SML);
        end else begin
          x_lo  <= XOFF_BIG;
          x_hi  <= XOFF_BIG + 10'(W_BIG);
          y_lo  <= YOFF_BIG;
          y_hi  <= YOFF_BIG + 10'(H_BIG);
          w_amp <= 10'(W_BIG);
        end
      end
    end
  end

  // A mode change or lost copy beats a coincident frame boundary
  always_comb begin
    next_state = state;
    case (state)
      WAIT_COPY:
        if (copy_done && seletor != 2'b11) next_state = WAIT_FRAME;
      WAIT_FRAME:
        if (!copy_done || seletor != entry_sel) next_state = WAIT_COPY;
        else if (boundary)                     next_state = ACTIVE;
      ACTIVE:
        if (!copy_done || seletor != mode_cur) next_state = WAIT_COPY;
      default:
        next_state = WAIT_COPY;
    endcase
  end

  always_comb begin
    active    = (state == ACTIVE);
    in_img    = (state == ACTIVE)
              && ({1'b0, next_x} < 11'(SCREEN_W)) && ({1'b0, next_y} < 11'(SCREEN_H))
              && (next_x >= x_lo) && (next_x < x_hi)
              && (next_y >= y_lo) && (next_y < y_hi);
    addr_calc = 19'(next_y - y_lo) * 19'(w_amp) + 19'(next_x - x_lo);
  end

  // Read pipeline; in-flight pixels are dropped as soon as ACTIVE is left
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_rdaddr  <= '0;
      color_out   <= '0;
      frame_start <= 1'b0;
      img_dly     <= '0;
    end else begin
      ram_rdaddr  <= in_img ? addr_calc : '0;
      frame_start <= (state == ACTIVE) && (next_state == ACTIVE) && boundary;
      if (next_state != ACTIVE) begin
        img_dly   <= '0;
        color_out <= '0;
      end else begin
        img_dly   <= {img_dly[RD_LAT-1:0], in_img};
        color_out <= img_dly[RD_LAT] ? ram_q : 8'h00;
      end
    end
  end

endmodule

// File: tb/tb_fb_reader.sv
// Directed bench for fb_reader: two instances (RD_LAT 1 and 2) share stimulus
// and each reads from a small behavioural RAM model of matching latency.
module tb_fb_reader;

  logic        clk;
  logic        reset;
  logic [1:0]  seletor;
  logic        copy_done;
  logic [9:0]  next_x, next_y;
  logic        const_en;
  logic [7:0]  const_val;

  logic [18:0] rdaddr1, rdaddr2;
  logic [7:0]  ram_q1, ram_q2, color1, color2;
  logic        active1, active2, fs1, fs2;
  logic [1:0]  mode1, mode2;
  logic [7:0]  q1_pipe, q2_pipe_a, q2_pipe_b;

  int checks = 0;
  int errors = 0;

  fb_reader #(.RD_LAT(1)) dut (
    .clk(clk), .reset(reset), .seletor(seletor), .copy_done(copy_done),
    .next_x(next_x), .next_y(next_y), .ram_rdaddr(rdaddr1), .ram_q(ram_q1),
    .color_out(color1), .active(active1), .mode_cur(mode1), .frame_start(fs1)
  );

  fb_reader #(.RD_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .seletor(seletor), .copy_done(copy_done),
    .next_x(next_x), .next_y(next_y), .ram_rdaddr(rdaddr2), .ram_q(ram_q2),
    .color_out(color2), .active(active2), .mode_cur(mode2), .frame_start(fs2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM content is address low byte xor 3C, unless a constant is forced
  always @(posedge clk) begin
    q1_pipe   <= rdaddr1[7:0] ^ 8'h3C;
    q2_pipe_a <= rdaddr2[7:0] ^ 8'h3C;
    q2_pipe_b <= q2_pipe_a;
  end
  assign ram_q1 = const_en ? const_val : q1_pipe;
  assign ram_q2 = const_en ? const_val : q2_pipe_b;

  task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input int cycles);
    next_x = x;
    next_y = y;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b0; seletor = 2'b00; copy_done = 1'b0;
    next_x = 10'd5; next_y = 10'd5; const_en = 1'b1; const_val = 8'hA5;
    @(negedge clk);
    applyStimulus(10'd5, 10'd5, 2);
    checkOutput("rst_addr", 32'(rdaddr1), 32'd0);
    checkOutput("rst_color", 32'(color1), 32'd0);
    checkOutput("rst_active", 32'(active1), 32'd0);
    checkOutput("rst_mode", 32'(mode1), 32'd3);
    checkOutput("rst_fs", 32'(fs1), 32'd0);

    // bring-up: nothing shown before the first boundary
    reset = 1'b1; copy_done = 1'b1;
    applyStimulus(10'd5, 10'd5, 2);
    checkOutput("wf_active", 32'(active1), 32'd0);
    applyStimulus(10'd200, 10'd200, 4);
    checkOutput("wf_color", 32'(color1), 32'd0);
    checkOutput("wf_addr", 32'(rdaddr1), 32'd0);
    applyStimulus(10'd0, 10'd0, 1);
    checkOutput("entry_active", 32'(active1), 32'd1);
    checkOutput("entry_mode", 32'(mode1), 32'd0);
    checkOutput("entry_fs", 32'(fs1), 32'd0);

    // mode 00 geometry
    applyStimulus(10'd160, 10'd120, 4);
    checkOutput("m0_first_addr", 32'(rdaddr1), 32'd0);
    checkOutput("m0_first_color", 32'(color1), 32'hA5);
    applyStimulus(10'd479, 10'd359, 4);
    checkOutput("m0_last_addr", 32'(rdaddr1), 32'd76799);
    checkOutput("m0_last_color", 32'(color1), 32'hA5);
    applyStimulus(10'd159, 10'd120, 4);
    checkOutput("m0_left_addr", 32'(rdaddr1), 32'd0);
    checkOutput("m0_left_color", 32'(color1), 32'd0);
    applyStimulus(10'd700, 10'd200, 4);
    checkOutput("m0_blank_color", 32'(color1), 32'd0);
    const_en = 1'b0;
    applyStimulus(10'd161, 10'd120, 4);
    checkOutput("m0_data_addr", 32'(rdaddr1), 32'd1);
    checkOutput("m0_data_color1", 32'(color1), 32'h3D);
    checkOutput("m0_data_color2", 32'(color2), 32'h3D);
    const_en = 1'b1;

    applyStimulus(10'd0, 10'd0, 1);
    checkOutput("fs_pulse1", 32'(fs1), 32'd1);
    checkOutput("fs_pulse2", 32'(fs2), 32'd1);
    applyStimulus(10'd5, 10'd5, 1);
    checkOutput("fs_low", 32'(fs1), 32'd0);

    // mid-frame switch to mode 01 with the copy redone
    applyStimulus(10'd300, 10'd200, 4);
    checkOutput("pre_switch_color", 32'(color1), 32'hA5);
    seletor = 2'b01; copy_done = 1'b0;
    applyStimulus(10'd300, 10'd200, 1);
    checkOutput("switch_active", 32'(active1), 32'd0);
    checkOutput("switch_color", 32'(color1), 32'd0);
    applyStimulus(10'd300, 10'd200, 9);
    copy_done = 1'b1;
    applyStimulus(10'd280, 10'd210, 4);
    checkOutput("switch_wait_color", 32'(color1), 32'd0);
    checkOutput("switch_wait_mode", 32'(mode1), 32'd0);
    applyStimulus(10'd0, 10'd0, 1);
    checkOutput("m1_mode", 32'(mode1), 32'd1);
    checkOutput("m1_active", 32'(active1), 32'd1);

    // mode 01 geometry and pipeline latency
    applyStimulus(10'd279, 10'd210, 4);
    checkOutput("m1_outside_color", 32'(color1), 32'd0);
    applyStimulus(10'd280, 10'd210, 2);
    checkOutput("lat_c2_dut1", 32'(color1), 32'd0);
    checkOutput("m1_first_addr", 32'(rdaddr1), 32'd0);
    applyStimulus(10'd280, 10'd210, 1);
    checkOutput("lat_c3_dut1", 32'(color1), 32'hA5);
    checkOutput("lat_c3_dut2", 32'(color2), 32'd0);
    applyStimulus(10'd280, 10'd210, 1);
    checkOutput("lat_c4_dut2", 32'(color2), 32'hA5);
    applyStimulus(10'd360, 10'd210, 4);
    checkOutput("m1_right_color", 32'(color1), 32'd0);
    checkOutput("m1_right_addr", 32'(rdaddr1), 32'd0);
    applyStimulus(10'd359, 10'd269, 4);
    checkOutput("m1_last_addr", 32'(rdaddr1), 32'd4799);
    checkOutput("m1_last_addr2", 32'(rdaddr2), 32'd4799);

    // invalid mode never displays
    seletor = 2'b11; const_val = 8'hFF;
    applyStimulus(10'd300, 10'd250, 1);
    checkOutput("inv_leave_active", 32'(active1), 32'd0);
    applyStimulus(10'd0, 10'd0, 1);
    applyStimulus(10'd300, 10'd250, 4);
    checkOutput("inv_active", 32'(active1), 32'd0);
    checkOutput("inv_color", 32'(color1), 32'd0);
    checkOutput("inv_mode", 32'(mode1), 32'd1);

    // asynchronous reset in the middle of a line
    seletor = 2'b00; const_val = 8'hA5;
    applyStimulus(10'd5, 10'd5, 2);
    applyStimulus(10'd0, 10'd0, 1);
    applyStimulus(10'd300, 10'd250, 4);
    checkOutput("pre_rst_color", 32'(color1), 32'hA5);
    #2 reset = 1'b0;
    #1;
    checkOutput("arst_color", 32'(color1), 32'd0);
    checkOutput("arst_addr", 32'(rdaddr1), 32'd0);
    checkOutput("arst_active", 32'(active1), 32'd0);
    checkOutput("arst_mode", 32'(mode1), 32'd3);
    @(negedge clk);
    reset = 1'b1;
    applyStimulus(10'd300, 10'd250, 4);
    checkOutput("post_rst_color", 32'(color1), 32'd0);
    checkOutput("post_rst_active", 32'(active1), 32'd0);
    applyStimulus(10'd0, 10'd0, 1);
    applyStimulus(10'd300, 10'd250, 4);
    checkOutput("post_rst_show", 32'(color1), 32'hA5);
    checkOutput("post_rst_mode", 32'(mode1), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
